// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg
//   Shared definitions for the two-master memory bus arbiter: default bus
//   widths, FSM state encoding, owner codes and small helper functions.
//   No ports (package).
package mem_bus_arbiter_pkg;

  localparam int DEF_ADDR_W = 13;
  localparam int DEF_DATA_W = 8;
  localparam int WAIT_W     = 4;   // wait-state counter width

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } arb_state_e;

  // Owner codes: which master holds the bus.
  localparam logic OWN_M0 = 1'b0;
  localparam logic OWN_M1 = 1'b1;

  // One-hot grant codes.
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  // A request must be exactly one of read or write.
  function automatic logic is_illegal(input logic rd, input logic wr);
    return rd == wr;
  endfunction

  function automatic logic [1:0] owner_gnt(input logic owner);
    return (owner == OWN_M1) ? GNT_M1 : GNT_M0;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_select.sv
// mem_bus_arbiter_rr_select
//   Combinational 2-way winner select.
//   Ports:
//     req    in  2  request vector {m1, m0}
//     last   in  1  owner served by the previous grant
//     owner  out 1  winning master (OWN_M0 / OWN_M1)
//     valid  out 1  at least one request present
module mem_bus_arbiter_rr_select
  import mem_bus_arbiter_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic [1:0] req,
  input  logic       last,
  output logic       owner,
  output logic       valid
);

  always_comb begin
    owner = OWN_M0;
    if (req == 2'b11) begin
      // Tie: round-robin hands the bus to whoever was not served last;
      // fixed priority always favours m0.
      owner = (RR_EN && (last == OWN_M0)) ? OWN_M1 : OWN_M0;
    end else if (req[1]) begin
      owner = OWN_M1;
    end
  end

  assign valid = |req;

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one ROM/RAM bus between m0 (CPU) and m1 (loader/debug DMA).
//   One access at a time: grant, hold strobes for WAIT_CYC+1 cycles, then a
//   one-cycle ack with read data back to the owner.
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     m{0,1}_req/rd/wr         request and access type (held until ack)
//     m{0,1}_addr/wdata        access address / write data
//     m{0,1}_ack/rdata         one-cycle completion pulse / read data
//     bus_addr/rd/wr/wdata     shared bus outputs
//     bus_rdata                data returned from rom/ram
//     gnt                      one-hot current owner, 00 when idle
//     err                      sticky illegal-request flag
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int          ADDR_W   = DEF_ADDR_W,
  parameter int          DATA_W   = DEF_DATA_W,
  parameter int unsigned WAIT_CYC = 1,
  parameter bit          RR_EN    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_rd,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_rd,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_rd,
  output logic              bus_wr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [1:0]        gnt,
  output logic              err
);

  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_CYC);

  arb_state_e        r_state;
  logic [WAIT_W-1:0] r_wait;
  logic              r_last;
  logic [1:0]        r_gnt;
  logic              r_bus_rd;
  logic              r_bus_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_m0_ack;
  logic              r_m1_ack;
  logic [DATA_W-1:0] r_m0_rdata;
  logic [DATA_W-1:0] r_m1_rdata;
  logic              r_err;

  logic              w_owner;
  logic              w_valid;
  logic              w_sel_rd;
  logic              w_sel_wr;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_ret_load;
  logic [DATA_W-1:0] w_ret_data;

  mem_bus_arbiter_rr_select #(
    .RR_EN(RR_EN)
  ) u_rr_select (
    .req   ({m1_req, m0_req}),
    .last  (r_last),
    .owner (w_owner),
    .valid (w_valid)
  );

  assign w_sel_rd    = (w_owner == OWN_M1) ? m1_rd    : m0_rd;
  assign w_sel_wr    = (w_owner == OWN_M1) ? m1_wr    : m0_wr;
  assign w_sel_addr  = (w_owner == OWN_M1) ? m1_addr  : m0_addr;
  assign w_sel_wdata = (w_owner == OWN_M1) ? m1_wdata : m0_wdata;

  // On the final access edge the strobes still reflect the request type:
  // a read returns bus data, an illegal request (no strobe) returns zero,
  // and a write leaves the owner's rdata untouched.
  assign w_ret_load = r_bus_rd | ~r_bus_wr;
  assign w_ret_data = r_bus_rd ? bus_rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_wait     <= '0;
      r_last     <= OWN_M1;   // m0 wins the first tie
      r_gnt      <= GNT_NONE;
      r_bus_rd   <= 1'b0;
      r_bus_wr   <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_m0_ack   <= 1'b0;
      r_m1_ack   <= 1'b0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
      r_err      <= 1'b0;
    end else begin
      r_m0_ack <= 1'b0;
      r_m1_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_gnt    <= owner_gnt(w_owner);
            r_last   <= w_owner;
            r_addr   <= w_sel_addr;
            r_wdata  <= w_sel_wdata;
            r_bus_rd <= w_sel_rd & ~w_sel_wr;
            r_bus_wr <= w_sel_wr & ~w_sel_rd;
            if (is_illegal(w_sel_rd, w_sel_wr)) begin
              r_err <= 1'b1;
            end
            r_wait  <= WAIT_INIT;
            r_state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (r_wait == '0) begin
            r_bus_rd <= 1'b0;
            r_bus_wr <= 1'b0;
            if (r_gnt == GNT_M1) begin
              r_m1_ack <= 1'b1;
              if (w_ret_load) r_m1_rdata <= w_ret_data;
            end else begin
              r_m0_ack <= 1'b1;
              if (w_ret_load) r_m0_rdata <= w_ret_data;
            end
            r_state <= ST_ACK;
          end else begin
            r_wait <= r_wait - WAIT_W'(1);
          end
        end
        ST_ACK: begin
          r_gnt   <= GNT_NONE;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign m0_ack    = r_m0_ack;
  assign m0_rdata  = r_m0_rdata;
  assign m1_ack    = r_m1_ack;
  assign m1_rdata  = r_m1_rdata;
  assign bus_addr  = r_addr;
  assign bus_rd    = r_bus_rd;
  assign bus_wr    = r_bus_wr;
  assign bus_wdata = r_wdata;
  assign gnt       = r_gnt;
  assign err       = r_err;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  localparam int WC = 1;

  typedef struct {
    bit         m;
    bit         rd;
    bit         wr;
    logic [12:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rdata;
    bit          exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m0_req = 0, m0_rd = 0, m0_wr = 0, m1_req = 0, m1_rd = 0, m1_wr = 0;
  logic [12:0] m0_addr = '0, m1_addr = '0;
  logic [7:0]  m0_wdata = '0, m1_wdata = '0;

  // index 0: round-robin instance, index 1: fixed-priority instance
  logic [1:0]  gnt_w [2];
  logic        bus_rd_w [2], bus_wr_w [2], ack0_w [2], ack1_w [2], err_w [2];
  logic [12:0] bus_addr_w [2];
  logic [7:0]  bus_wdata_w [2], bus_rdata_w [2], rdata0_w [2], rdata1_w [2];

  logic [7:0] mem [2][8192];
  bit         wr_valid [2][8192];

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(13), .DATA_W(8), .WAIT_CYC(WC), .RR_EN(1'b1)) u_dut_rr (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_rd(m0_rd), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(ack0_w[0]), .m0_rdata(rdata0_w[0]),
    .m1_req(m1_req), .m1_rd(m1_rd), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(ack1_w[0]), .m1_rdata(rdata1_w[0]),
    .bus_addr(bus_addr_w[0]), .bus_rd(bus_rd_w[0]), .bus_wr(bus_wr_w[0]),
    .bus_wdata(bus_wdata_w[0]), .bus_rdata(bus_rdata_w[0]),
    .gnt(gnt_w[0]), .err(err_w[0])
  );

  mem_bus_arbiter #(.ADDR_W(13), .DATA_W(8), .WAIT_CYC(WC), .RR_EN(1'b0)) u_dut_fp (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_rd(m0_rd), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(ack0_w[1]), .m0_rdata(rdata0_w[1]),
    .m1_req(m1_req), .m1_rd(m1_rd), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(ack1_w[1]), .m1_rdata(rdata1_w[1]),
    .bus_addr(bus_addr_w[1]), .bus_rd(bus_rd_w[1]), .bus_wr(bus_wr_w[1]),
    .bus_wdata(bus_wdata_w[1]), .bus_rdata(bus_rdata_w[1]),
    .gnt(gnt_w[1]), .err(err_w[1])
  );

  // ROM contents for never-written locations
  function automatic logic [7:0] init_val(input logic [12:0] a);
    if (a == 13'h1FFF) return 8'hA5;
    return a[7:0] ^ {3'b101, a[12:8]};
  endfunction

  assign bus_rdata_w[0] = wr_valid[0][bus_addr_w[0]] ? mem[0][bus_addr_w[0]] : init_val(bus_addr_w[0]);
  assign bus_rdata_w[1] = wr_valid[1][bus_addr_w[1]] ? mem[1][bus_addr_w[1]] : init_val(bus_addr_w[1]);

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (bus_wr_w[i]) begin
        mem[i][bus_addr_w[i]]      <= bus_wdata_w[i];
        wr_valid[i][bus_addr_w[i]] <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- transaction-level reference model ----------------
  // Each instance is either idle or serving one transaction; p counts edges
  // since the grant: strobes for p=0..WC, ack at p=WC+1, free at p=WC+2.
  bit          busy [2];
  int          p [2];
  bit          own [2], last_srv [2], mrd [2], mwr [2], merr [2];
  logic [12:0] maddr [2];
  logic [7:0]  mwd [2], mexp [2];
  bit [7:0]    ref_mem [2][8192];
  bit          ref_v [2][8192];
  bit          rr_mode [2] = '{1'b1, 1'b0};

  function automatic logic [7:0] ref_rd(input int i, input logic [12:0] a);
    return ref_v[i][a] ? ref_mem[i][a] : init_val(a);
  endfunction

  task automatic model_step(input int i);
    if (rst) begin
      busy[i] = 0; last_srv[i] = 1; merr[i] = 0;
    end else if (busy[i]) begin
      p[i]++;
      if (p[i] == WC + 2) busy[i] = 0;
    end else if (m0_req || m1_req) begin
      if (m0_req && m1_req) own[i] = rr_mode[i] ? !last_srv[i] : 1'b0;
      else                  own[i] = m1_req;
      last_srv[i] = own[i];
      mrd[i]   = own[i] ? m1_rd : m0_rd;
      mwr[i]   = own[i] ? m1_wr : m0_wr;
      maddr[i] = own[i] ? m1_addr : m0_addr;
      mwd[i]   = own[i] ? m1_wdata : m0_wdata;
      if (mrd[i] == mwr[i]) begin
        merr[i] = 1; mexp[i] = 8'h00;
      end else if (mrd[i]) begin
        mexp[i] = ref_rd(i, maddr[i]);
      end else begin
        ref_mem[i][maddr[i]] = mwd[i]; ref_v[i][maddr[i]] = 1;
      end
      busy[i] = 1; p[i] = 0;
    end
  endtask

  task automatic model_check(input int i);
    bit act, ak, legal;
    act   = busy[i] && (p[i] <= WC);
    ak    = busy[i] && (p[i] == WC + 1);
    legal = (mrd[i] != mwr[i]);
    chk($sformatf("d%0d_gnt", i), gnt_w[i], busy[i] ? (own[i] ? 2'b10 : 2'b01) : 2'b00);
    chk($sformatf("d%0d_bus_rd", i), bus_rd_w[i], act && legal && mrd[i]);
    chk($sformatf("d%0d_bus_wr", i), bus_wr_w[i], act && legal && mwr[i]);
    chk($sformatf("d%0d_ack0", i), ack0_w[i], ak && !own[i]);
    chk($sformatf("d%0d_ack1", i), ack1_w[i], ak && own[i]);
    chk($sformatf("d%0d_err", i), err_w[i], merr[i]);
    if (act && legal) chk($sformatf("d%0d_bus_addr", i), bus_addr_w[i], maddr[i]);
    if (act && legal && mwr[i]) chk($sformatf("d%0d_bus_wdata", i), bus_wdata_w[i], mwd[i]);
    if (ak && !(legal && mwr[i]))
      chk($sformatf("d%0d_rdata", i), own[i] ? rdata1_w[i] : rdata0_w[i], mexp[i]);
    if (rst) begin
      chk($sformatf("d%0d_rst_addr", i), bus_addr_w[i], 0);
      chk($sformatf("d%0d_rst_wdata", i), bus_wdata_w[i], 0);
      chk($sformatf("d%0d_rst_rdata", i), {rdata1_w[i], rdata0_w[i]}, 0);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        model_step(i);
        model_check(i);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit m, input bit req, input bit rd, input bit wr,
                       input logic [12:0] addr, input logic [7:0] wdata);
    if (m) begin m1_req = req; m1_rd = rd; m1_wr = wr; m1_addr = addr; m1_wdata = wdata; end
    else   begin m0_req = req; m0_rd = rd; m0_wr = wr; m0_addr = addr; m0_wdata = wdata; end
  endtask

  task automatic new_req(input bit m);
    int r;
    bit rd, wr;
    r = $urandom_range(7, 0);
    if (r == 0) begin rd = $urandom_range(1, 0); wr = rd; end
    else begin rd = (r < 4); wr = !rd; end
    drive(m, 1'b1, rd, wr, 13'h1800 + 13'($urandom_range(7, 0)), 8'($urandom_range(255, 0)));
  endtask

  // Waits for the RR instance's ack of master m; returns edges taken (-1 on timeout).
  task automatic wait_ack(input bit m, output int n, output int n_st);
    bit got;
    n = 0; n_st = 0; got = 0;
    while (!got && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (bus_rd_w[0] || bus_wr_w[0]) n_st++;
      got = m ? ack1_w[0] : ack0_w[0];
    end
    if (!got) n = -1;
  endtask

  task automatic run_vec(input int k, input vec_t v);
    int n, n_st;
    bit legal;
    legal = (v.rd != v.wr);
    @(negedge clk); #1;
    drive(v.m, 1'b1, v.rd, v.wr, v.addr, v.wdata);
    wait_ack(v.m, n, n_st);
    chk($sformatf("vec%0d_latency", k), n, WC + 2);
    chk($sformatf("vec%0d_strobe_cycles", k), n_st, legal ? WC + 1 : 0);
    if (!(legal && v.wr))
      chk($sformatf("vec%0d_rdata", k), v.m ? rdata1_w[0] : rdata0_w[0], v.exp_rdata);
    chk($sformatf("vec%0d_err", k), err_w[0], v.exp_err);
    $display("vec%0d m%0d rd=%0d wr=%0d addr=%h wdata=%h latency=%0d", k, v.m, v.rd, v.wr, v.addr, v.wdata, n);
    @(negedge clk); #1;
    drive(v.m, 1'b0, 1'b0, 1'b0, '0, '0);
    if (legal && v.wr) begin
      chk($sformatf("vec%0d_ram", k), mem[0][v.addr], v.wdata);
    end
  endtask

  // ---------------- main test ----------------
  initial begin
    vec_t tbl [8];
    int   q0 [$];
    int   q1 [$];
    int   fp0, fp1, fp_g10, n, n_st;

    tbl[0] = '{m:1'b0, rd:1'b1, wr:1'b0, addr:13'h1FFF, wdata:8'h00, exp_rdata:8'hA5, exp_err:1'b0};
    tbl[1] = '{m:1'b1, rd:1'b0, wr:1'b1, addr:13'h1802, wdata:8'h3C, exp_rdata:8'h00, exp_err:1'b0};
    tbl[2] = '{m:1'b1, rd:1'b1, wr:1'b0, addr:13'h1802, wdata:8'h00, exp_rdata:8'h3C, exp_err:1'b0};
    tbl[3] = '{m:1'b0, rd:1'b1, wr:1'b0, addr:13'h0040, wdata:8'h00, exp_rdata:init_val(13'h0040), exp_err:1'b0};
    tbl[4] = '{m:1'b0, rd:1'b0, wr:1'b1, addr:13'h0040, wdata:8'h5A, exp_rdata:8'h00, exp_err:1'b0};
    tbl[5] = '{m:1'b0, rd:1'b1, wr:1'b0, addr:13'h0040, wdata:8'h00, exp_rdata:8'h5A, exp_err:1'b0};
    tbl[6] = '{m:1'b0, rd:1'b1, wr:1'b1, addr:13'h0100, wdata:8'h77, exp_rdata:8'h00, exp_err:1'b1};
    tbl[7] = '{m:1'b1, rd:1'b0, wr:1'b0, addr:13'h0101, wdata:8'h00, exp_rdata:8'h00, exp_err:1'b1};

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b0;

    for (int k = 0; k < 8; k++) run_vec(k, tbl[k]);

    // Both masters hold requests: RR alternates m0,m1 (m0 first, since the
    // table finished with m1); fixed priority serves only m0.
    @(negedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 13'h1FFF, 8'h00);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 13'h1802, 8'h00);
    fp0 = 0; fp1 = 0; fp_g10 = 0;
    for (int e = 1; e <= 24; e++) begin
      @(posedge clk); #1;
      if (ack0_w[0]) q0.push_back(e);
      if (ack1_w[0]) q1.push_back(e);
      if (ack0_w[1]) fp0++;
      if (ack1_w[1]) fp1++;
      if (gnt_w[1] == 2'b10) fp_g10++;
    end
    @(negedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    chk("rr_m0_ack_count", q0.size(), 3);
    chk("rr_m1_ack_count", q1.size(), 3);
    for (int j = 0; j < 3; j++) begin
      if (j < q0.size()) chk($sformatf("rr_m0_ack_time%0d", j), q0[j], (WC + 2) + j * 2 * (WC + 3));
      if (j < q1.size()) chk($sformatf("rr_m1_ack_time%0d", j), q1[j], (WC + 2) + (WC + 3) + j * 2 * (WC + 3));
    end
    chk("fp_m0_ack_count", fp0, 24 / (WC + 3));
    chk("fp_m1_ack_count", fp1, 0);
    chk("fp_gnt10_cycles", fp_g10, 0);
    $display("contention rr m0_acks=%0d m1_acks=%0d fp m0_acks=%0d m1_acks=%0d", q0.size(), q1.size(), fp0, fp1);

    // Reset in the middle of an access, then retry.
    @(negedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 13'h1FFF, 8'h00);
    @(posedge clk); #3;
    chk("pre_rst_bus_rd", bus_rd_w[0], 1);
    chk("pre_rst_err", err_w[0], 1);
    rst = 1'b1;
    #1;
    chk("rst_async_bus_rd", bus_rd_w[0], 0);
    chk("rst_async_gnt", gnt_w[0], 0);
    chk("rst_async_ack", ack0_w[0], 0);
    chk("rst_async_err", err_w[0], 0);
    @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b0;
    wait_ack(1'b0, n, n_st);
    chk("retry_latency", n, WC + 2);
    chk("retry_rdata", rdata0_w[0], 8'hA5);
    $display("reset mid-access: retry latency=%0d rdata=%h", n, rdata0_w[0]);
    @(negedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);

    // Random traffic, checked cycle-by-cycle by the reference model.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk); #1;
      if (m0_req && ack0_w[0]) begin
        if ($urandom_range(1, 0) == 1) new_req(1'b0);
        else drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
      end else if (!m0_req && $urandom_range(2, 0) == 0) new_req(1'b0);
      if (m1_req && ack1_w[0]) begin
        if ($urandom_range(1, 0) == 1) new_req(1'b1);
        else drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      end else if (!m1_req && $urandom_range(2, 0) == 0) new_req(1'b1);
    end
    @(negedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (10) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
